// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired sequencer: opcodes, function-select
// codes, FSM states, control-word layout and the decoded-instruction record.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU0 = 4'h1;
  localparam logic [3:0] OP_ALU1 = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BRZ  = 4'h7;
  localparam logic [3:0] OP_BRN  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_MOVB = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EX1,
    S_EX2,
    S_EX3,
    S_HALT
  } state_t;

  // Control word layout: DA[15:13] AA[12:10] BA[9:7] MB[6] FS[5:2] MD[1] RW[0]
  localparam int DA_MSB = 15;
  localparam int DA_LSB = 13;
  localparam int AA_MSB = 12;
  localparam int AA_LSB = 10;
  localparam int BA_MSB = 9;
  localparam int BA_LSB = 7;
  localparam int MB_BIT = 6;
  localparam int FS_MSB = 5;
  localparam int FS_LSB = 2;
  localparam int MD_BIT = 1;
  localparam int RW_BIT = 0;

  typedef struct packed {
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic        mb;
    logic [3:0]  fs;
    logic        md;
    logic        writes;
    logic        is_st;
    logic        is_br;
    logic        br_on_n;
    logic        is_jmp;
    logic        is_halt;
    logic        illegal;
    logic [15:0] cin;
  } dec_t;

  // Assemble a control word from decoded fields with the given RW bit
  function automatic logic [15:0] pack_cw(input dec_t d, input logic rw);
    logic [15:0] w;
    w = '0;
    w[DA_MSB:DA_LSB] = d.da;
    w[AA_MSB:AA_LSB] = d.aa;
    w[BA_MSB:BA_LSB] = d.ba;
    w[MB_BIT]        = d.mb;
    w[FS_MSB:FS_LSB] = d.fs;
    w[MD_BIT]        = d.md;
    w[RW_BIT]        = rw;
    return w;
  endfunction

endpackage

// File: rtl/cw_decode.sv
// Combinational instruction decoder: instruction word to control fields,
// constant bus value and instruction-class flags.
module cw_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  logic [3:0] op;
  assign op = ir[15:12];

  // Register selects pass straight through; opcode selects the rest
  always_comb begin
    dec    = '0;
    dec.da = ir[11:9];
    dec.aa = ir[8:6];
    dec.ba = ir[5:3];
    case (op)
      OP_NOP: ;
      OP_ALU0: begin
        dec.fs     = {1'b0, ir[2:0]};
        dec.writes = 1'b1;
      end
      OP_ALU1: begin
        dec.fs     = {1'b1, ir[2:0]};
        dec.writes = 1'b1;
      end
      OP_ADDI: begin
        dec.fs     = FS_ADD;
        dec.mb     = 1'b1;
        dec.cin    = {10'd0, ir[5:0]};
        dec.writes = 1'b1;
      end
      OP_LDI: begin
        dec.fs     = FS_MOVB;
        dec.mb     = 1'b1;
        dec.cin    = {10'd0, ir[5:0]};
        dec.writes = 1'b1;
      end
      OP_LD: begin
        dec.md     = 1'b1;
        dec.writes = 1'b1;
      end
      OP_ST:   dec.is_st = 1'b1;
      OP_BRZ: begin
        dec.fs    = FS_MOVA;
        dec.is_br = 1'b1;
      end
      OP_BRN: begin
        dec.fs      = FS_MOVA;
        dec.is_br   = 1'b1;
        dec.br_on_n = 1'b1;
      end
      OP_JMP:  dec.is_jmp  = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: fetches from the instruction ROM at PC, holds the
// instruction in IR and steps it through FETCH/EX1/EX2/EX3, driving the
// datapath control word, constant bus, memory write and PC update.
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [15:0] Instr,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic [15:0] PC,
  output logic [15:0] CTRWRD,
  output logic [15:0] Cin,
  output logic        MW,
  output logic        halted,
  output logic        illegal
);

  state_t      state;
  logic [15:0] ir;
  logic [15:0] dec_in;
  dec_t        dec;
  logic        taken;
  logic [15:0] pc_inc;
  logic [15:0] br_target;
  logic        flags_unused;

  // Overflow and carry play no part in branch resolution
  assign flags_unused = V ^ C;

  // Outputs are registered, so the word entering EX1 must be decoded while
  // it is still on the ROM bus; afterwards IR is the source.
  assign dec_in = (state == S_FETCH) ? Instr : ir;

  cw_decode u_decode (
    .ir  (dec_in),
    .dec (dec)
  );

  assign taken     = dec.is_br & (dec.br_on_n ? N : Z);
  assign pc_inc    = PC + 16'd1;
  assign br_target = pc_inc + {{10{ir[5]}}, ir[5:0]};

  // Sequencer FSM with registered control outputs and PC/IR update
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      PC      <= PC_RESET;
      ir      <= '0;
      CTRWRD  <= '0;
      Cin     <= '0;
      MW      <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      MW      <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          ir     <= Instr;
          CTRWRD <= pack_cw(dec, 1'b0);
          Cin    <= dec.cin;
          state  <= S_EX1;
        end
        S_EX1: begin
          MW    <= dec.is_st;
          state <= S_EX2;
        end
        S_EX2: begin
          CTRWRD[RW_BIT] <= dec.writes;
          illegal        <= dec.illegal;
          state          <= S_EX3;
        end
        S_EX3: begin
          CTRWRD <= '0;
          Cin    <= '0;
          if (dec.is_halt) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            if (dec.is_jmp)  PC <= {4'd0, ir[11:0]};
            else if (taken)  PC <= br_target;
            else             PC <= pc_inc;
            state <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
